zmul_seq: RTL

Parametrised, time-multiplexed successor to the fixed 4×4 z·(zᵀw)³ product stage of the one-unit FastICA datapath. For each of N matrices M_k, computes o[k][l] = Σ_j z[j]·M_k[j][l] in signed Q(W−FRAC).FRAC. It reuses N multipliers over N·N cycles instead of N³ in parallel, and rounds and saturates rather than truncating. Sits between the cube stage and the expectation/normalisation stage, under start/done control from the iteration FSM.

---
 rtl/zmul_pkg.sv | 31 +++
 rtl/zmul_round_sat.sv | 36 +++
 rtl/zmul_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/zmul_pkg.sv
// Shared types and constant helpers for the time-multiplexed z*M product stage.
package zmul_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_COPY = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Accumulator holds n products of two w-bit signed operands without overflow.
   function automatic int acc_width(input int n, input int w);
      return 2 * w + $clog2(n);
   endfunction

   // Half an LSB of the output format, added before the arithmetic right shift.
   function automatic longint rnd_const(input int frac);
      return (frac > 0) ? (longint'(1) <<< (frac - 1)) : longint'(0);
   endfunction

   // Largest representable w-bit signed value.
   function automatic longint sat_hi(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   // Smallest representable w-bit signed value.
   function automatic longint sat_lo(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/zmul_round_sat.sv
// Converts one wide accumulator to a W-bit result: round half up, arithmetic
// shift by FRAC, clamp to the signed W-bit range and flag any clamp.
module zmul_round_sat
   import zmul_pkg::*;
#(
   parameter int W     = 26,
   parameter int FRAC  = 13,
   parameter int ACC_W = 54
)(
   input  logic [ACC_W-1:0] acc_i,
   output logic [W-1:0]     res_o,
   output logic             ovf_o
);

   // One guard bit so adding the rounding constant can never wrap.
   localparam int EW = ACC_W + 1;
   localparam logic signed [EW-1:0] RND = EW'(rnd_const(FRAC));
   localparam logic signed [EW-1:0] HI  = EW'(sat_hi(W));
   localparam logic signed [EW-1:0] LO  = EW'(sat_lo(W));

   function automatic logic [W:0] round_sat(input logic signed [EW-1:0] a);
      logic signed [EW-1:0] shf;
      shf = (a + RND) >>> FRAC;
      if (shf > HI) begin
         return {1'b1, HI[W-1:0]};
      end else if (shf < LO) begin
         return {1'b1, LO[W-1:0]};
      end else begin
         return {1'b0, shf[W-1:0]};
      end
   endfunction

   // Sign-extend the accumulator into the guarded width, then round and clamp.
   always_comb {ovf_o, res_o} = round_sat($signed({acc_i[ACC_W-1], acc_i}));

endmodule

// File: rtl/zmul_seq.sv
// Time-multiplexed product stage: for each of N matrices M_k computes
// o[k][l] = sum_j z[j]*M_k[j][l] with N multipliers over N*N cycles, rounding
// and saturating each row into signed Q(W-FRAC).FRAC. A bypass mode copies
// row 0 of every M_k straight to the output.
module zmul_seq
   import zmul_pkg::*;
#(
   parameter int N    = 4,
   parameter int W    = 26,
   parameter int FRAC = 13
)(
   input  logic               clk_mul,
   input  logic               rst_mul,
   input  logic               start,
   input  logic               bypass,
   input  logic [N*W-1:0]     z_flat,
   input  logic [N*N*N*W-1:0] m_flat,
   output logic               busy,
   output logic               done,
   output logic               o_valid,
   output logic               sat,
   output logic [N*N*W-1:0]   o_flat
);

   localparam int ACC_W = acc_width(N, W);
   localparam int CW    = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t state_q, state_d;
   logic [CW-1:0] k_q, k_d, j_q, j_d;
   logic busy_q, busy_d, done_q, done_d, o_valid_q, o_valid_d, sat_q, sat_d;

   logic signed [ACC_W-1:0] acc_q [N];
   logic signed [ACC_W-1:0] acc_d [N];
   logic signed [ACC_W-1:0] acc_sum [N];
   logic signed [W-1:0]     rnd [N];
   logic [N-1:0]            ovf;

   logic signed [W-1:0] z_arr [N];
   logic signed [W-1:0] m_arr [N][N][N];
   logic signed [W-1:0] o_q [N][N];
   logic signed [W-1:0] o_d [N][N];

   // Array views of the flat buses so indexing by the counters stays simple.
   for (genvar gj = 0; gj < N; gj++) begin : g_z
      assign z_arr[gj] = z_flat[gj*W +: W];
   end

   for (genvar gk = 0; gk < N; gk++) begin : g_mk
      for (genvar gj = 0; gj < N; gj++) begin : g_mj
         for (genvar gl = 0; gl < N; gl++) begin : g_ml
            assign m_arr[gk][gj][gl] = m_flat[((gk*N+gj)*N+gl)*W +: W];
         end
      end
      for (genvar gl = 0; gl < N; gl++) begin : g_o
         assign o_flat[(gk*N+gl)*W +: W] = o_q[gk][gl];
      end
   end

   // One multiplier per output column; each feeds its running sum and a rounder.
   for (genvar gl = 0; gl < N; gl++) begin : g_mul
      logic signed [2*W-1:0] prod;
      assign prod = (2*W)'(z_arr[j_q]) * (2*W)'(m_arr[k_q][j_q][gl]);
      assign acc_sum[gl] = acc_q[gl] + {{(ACC_W-2*W){prod[2*W-1]}}, prod};

      zmul_round_sat #(
         .W     (W),
         .FRAC  (FRAC),
         .ACC_W (ACC_W)
      ) u_round_sat (
         .acc_i (acc_sum[gl]),
         .res_o (rnd[gl]),
         .ovf_o (ovf[gl])
      );
   end

   // Next-state logic: sequencing of (k, j), row write-back and output flags.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      j_d       = j_q;
      acc_d     = acc_q;
      o_d       = o_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      o_valid_d = o_valid_q;
      sat_d     = sat_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               busy_d    = 1'b1;
               o_valid_d = 1'b0;
               sat_d     = 1'b0;
               if (bypass) begin
                  state_d = ST_COPY;
               end else begin
                  state_d = ST_RUN;
                  k_d     = '0;
                  j_d     = '0;
                  for (int l = 0; l < N; l++) acc_d[l] = '0;
               end
            end
         end
         ST_RUN: begin
            if (j_q == LAST) begin
               // Last term of row k: round the full sum straight into o[k][*].
               for (int kk = 0; kk < N; kk++) begin
                  if (k_q == CW'(kk)) begin
                     for (int l = 0; l < N; l++) o_d[kk][l] = rnd[l];
                  end
               end
               for (int l = 0; l < N; l++) acc_d[l] = '0;
               sat_d = sat_q | (|ovf);
               j_d   = '0;
               if (k_q == LAST) begin
                  k_d     = '0;
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end else begin
               acc_d = acc_sum;
               j_d   = j_q + 1'b1;
            end
         end
         ST_COPY: begin
            for (int kk = 0; kk < N; kk++) begin
               for (int l = 0; l < N; l++) o_d[kk][l] = m_arr[kk][0][l];
            end
            state_d = ST_DONE;
            done_d  = 1'b1;
         end
         ST_DONE: begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            o_valid_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, counters, accumulators and registered outputs; reset clears all.
   always_ff @(posedge clk_mul) begin
      if (rst_mul) begin
         state_q   <= ST_IDLE;
         k_q       <= '0;
         j_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         o_valid_q <= 1'b0;
         sat_q     <= 1'b0;
         for (int l = 0; l < N; l++) acc_q[l] <= '0;
         for (int kk = 0; kk < N; kk++) begin
            for (int l = 0; l < N; l++) o_q[kk][l] <= '0;
         end
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         j_q       <= j_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         o_valid_q <= o_valid_d;
         sat_q     <= sat_d;
         acc_q     <= acc_d;
         o_q       <= o_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign o_valid = o_valid_q;
   assign sat     = sat_q;

endmodule
